// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-counter width; callers guarantee value >= 2 so the result is >= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial-side signals of the transmitter, plus its FSM state for checkers.
interface piso_serializer_if
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 4
);

  // Load handshake: a word transfers on a posedge where load_valid and load_ready
  // are both high. The source holds load_valid and load_data stable until then;
  // load_ready may rise or fall regardless of load_valid.
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;

  logic             serial_out;
  logic             serial_valid;
  logic             busy;
  logic             done;
  state_e           dbg_state;

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output serial_out,
    output serial_valid,
    output busy,
    output done,
    output dbg_state
  );

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  serial_out,
    input  serial_valid,
    input  busy,
    input  done,
    input  dbg_state
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: captures a word on the load handshake and shifts it
// out one bit per clock, reloading on the last bit so consecutive words stream gap-free.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst,
  piso_serializer_if.slave bus
);

  localparam int             CW       = clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_done;
  logic             w_done_nxt;

  logic             w_shifting;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_shifted;
  logic             w_out_bit;

  // The output end of the register depends on bit order; zeros fill the far end.
  if (MSB_FIRST) begin : g_msb_first
    assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    assign w_out_bit = r_shreg[WIDTH-1];
  end else begin : g_lsb_first
    assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    assign w_out_bit = r_shreg[0];
  end

  assign w_shifting = (r_state == ST_SHIFT);
  assign w_last     = w_shifting && (r_cnt == '0);
  assign w_ready    = !rst && ((r_state == ST_IDLE) || w_last);
  assign w_accept   = bus.load_valid && w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_shreg_nxt = bus.load_data;
          w_cnt_nxt   = CNT_LAST;
        end
      end
      ST_SHIFT: begin
        if (!w_last) begin
          w_shreg_nxt = w_shifted;
          w_cnt_nxt   = r_cnt - 1'b1;
        end else begin
          // Word complete: done follows even when the next word is loaded on this edge.
          w_done_nxt = 1'b1;
          if (w_accept) begin
            w_shreg_nxt = bus.load_data;
            w_cnt_nxt   = CNT_LAST;
          end else begin
            w_state_nxt = ST_IDLE;
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_shreg_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.load_ready   = w_ready;
  assign bus.serial_valid = w_shifting;
  assign bus.busy         = w_shifting;
  assign bus.serial_out   = w_shifting && w_out_bit;
  assign bus.done         = r_done;
  assign bus.dbg_state    = r_state;

  a_cnt_zero_in_idle: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_IDLE) |-> (r_cnt == '0));

  a_done_one_cycle: assert property (@(posedge clk) disable iff (rst)
    r_done |=> !r_done);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances driven in lockstep, with a
// SIPO loopback model on the MSB-first line.
module tb_piso_serializer;
  import piso_serializer_pkg::*;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_msb;  // bit order on the line, first bit in [W-1]
    logic [W-1:0] exp_lsb;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         lv;
  logic [W-1:0] ld;
  logic [W-1:0] sipo;

  int n_checks;
  int n_fail;

  logic [0:0]   exp_m_q[$];
  logic [0:0]   exp_l_q[$];
  logic [W-1:0] word_q[$];

  piso_serializer_if #(.WIDTH(W)) m_if ();
  piso_serializer_if #(.WIDTH(W)) l_if ();

  assign m_if.load_valid = lv;
  assign m_if.load_data  = ld;
  assign l_if.load_valid = lv;
  assign l_if.load_data  = ld;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (m_if.slave)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (l_if.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Receiving 4-bit SIPO fed from the MSB-first line.
  initial sipo = '0;
  always @(posedge clk) begin
    if (m_if.serial_valid) sipo <= {sipo[W-2:0], m_if.serial_out};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: bits popped as they appear, loopback word checked at each done
  always @(negedge clk) begin
    if (!rst) begin
      if (m_if.serial_valid) begin
        if (exp_m_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL msb_bit: unexpected bit %0b, expected none (t=%0t)", m_if.serial_out, $time);
        end else chk("msb_bit", 32'(m_if.serial_out), 32'(exp_m_q.pop_front()));
      end
      if (l_if.serial_valid) begin
        if (exp_l_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL lsb_bit: unexpected bit %0b, expected none (t=%0t)", l_if.serial_out, $time);
        end else chk("lsb_bit", 32'(l_if.serial_out), 32'(exp_l_q.pop_front()));
      end
      if (m_if.done || l_if.done) chk("done_align", 32'(l_if.done), 32'(m_if.done));
      if (m_if.done) begin
        if (word_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done_pulse: got unexpected done, expected none (t=%0t)", $time);
        end else chk("sipo_loopback", 32'(sipo), 32'(word_q.pop_front()));
      end
    end
  end

  task automatic push_exp(input vec_t v);
    for (int i = W - 1; i >= 0; i--) begin
      exp_m_q.push_back(v.exp_msb[i]);
      exp_l_q.push_back(v.exp_lsb[i]);
    end
    word_q.push_back(v.data);
  endtask

  // Offers a word and returns in the cycle its first bit is on the line.
  task automatic send(input vec_t v);
    int guard;
    lv = 1'b1;
    ld = v.data;
    guard = 0;
    while (!m_if.load_ready && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: load_ready=%0b, expected 1 within 20 cycles", m_if.load_ready);
      lv = 1'b0;
    end else begin
      push_exp(v);
      step();
      lv = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (m_if.busy && guard < 40) begin
      step();
      guard++;
    end
    chk("idle_busy", 32'(m_if.busy), 32'd0);
    chk("idle_ready", 32'(m_if.load_ready), 32'd1);
    step();
  endtask

  vec_t vecs[6];
  vec_t v1011, v0110, v1111, v0101;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    v1011 = '{4'b1011, 4'b1011, 4'b1101};
    v0110 = '{4'b0110, 4'b0110, 4'b0110};
    v1111 = '{4'b1111, 4'b1111, 4'b1111};
    v0101 = '{4'b0101, 4'b0101, 4'b1010};
    vecs[0] = v1011;
    vecs[1] = '{4'b1000, 4'b1000, 4'b0001};
    vecs[2] = '{4'b0001, 4'b0001, 4'b1000};
    vecs[3] = '{4'b0000, 4'b0000, 4'b0000};
    vecs[4] = v1111;
    vecs[5] = '{4'b1100, 4'b1100, 4'b0011};

    // reset held for two edges
    rst = 1'b1;
    lv  = 1'b0;
    ld  = '0;
    step();
    step();
    chk("rst_serial_valid", 32'(m_if.serial_valid), 32'd0);
    chk("rst_serial_out", 32'(m_if.serial_out), 32'd0);
    chk("rst_busy", 32'(m_if.busy), 32'd0);
    chk("rst_done", 32'(m_if.done), 32'd0);
    chk("rst_load_ready", 32'(m_if.load_ready), 32'd0);
    chk("rst_state", 32'(m_if.dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(m_if.load_ready), 32'd1);
    step();

    // single word with per-cycle timing
    send(v1011);
    for (int i = 0; i < W; i++) begin
      chk("single_valid", 32'(m_if.serial_valid), 32'd1);
      chk("single_busy", 32'(m_if.busy), 32'd1);
      chk("single_done_low", 32'(m_if.done), 32'd0);
      chk("single_ready", 32'(m_if.load_ready), 32'(i == W - 1));
      step();
    end
    chk("single_done", 32'(m_if.done), 32'd1);
    chk("single_end_valid", 32'(m_if.serial_valid), 32'd0);
    chk("single_end_ready", 32'(m_if.load_ready), 32'd1);
    step();
    chk("single_done_clear", 32'(m_if.done), 32'd0);
    step();

    // table of words, each sent from idle
    for (int k = 0; k < 6; k++) begin
      send(vecs[k]);
      wait_idle();
    end

    // back-to-back with load_valid held high
    lv = 1'b1;
    ld = v1011.data;
    chk("b2b_ready0", 32'(m_if.load_ready), 32'd1);
    push_exp(v1011);
    step();
    ld = v0110.data;
    for (int i = 0; i < 2 * W; i++) begin
      chk("b2b_valid", 32'(m_if.serial_valid), 32'd1);
      chk("b2b_done", 32'(m_if.done), 32'(i == W));
      if (i == W - 1) begin
        chk("b2b_ready_last", 32'(m_if.load_ready), 32'd1);
        push_exp(v0110);
      end
      step();
      if (i == W - 1) lv = 1'b0;
    end
    chk("b2b_final_done", 32'(m_if.done), 32'd1);
    chk("b2b_final_valid", 32'(m_if.serial_valid), 32'd0);
    step();

    // load offered while busy is held off until the last bit
    send(v1011);
    step();
    lv = 1'b1;
    ld = v1111.data;
    #1;
    chk("busy_reject_ready", 32'(m_if.load_ready), 32'd0);
    step();
    chk("busy_reject_ready2", 32'(m_if.load_ready), 32'd0);
    send(v1111);
    wait_idle();

    // reset after two bits abandons the word
    send(v1011);
    step();
    rst = 1'b1;
    step();
    chk("midrst_valid", 32'(m_if.serial_valid), 32'd0);
    chk("midrst_busy", 32'(m_if.busy), 32'd0);
    chk("midrst_done", 32'(m_if.done), 32'd0);
    chk("midrst_ready", 32'(m_if.load_ready), 32'd0);
    exp_m_q.delete();
    exp_l_q.delete();
    word_q.delete();
    rst = 1'b0;
    step();
    chk("midrst_no_done", 32'(m_if.done), 32'd0);
    chk("midrst_ready_back", 32'(m_if.load_ready), 32'd1);
    step();
    chk("midrst_no_done2", 32'(m_if.done), 32'd0);
    send(v0101);
    wait_idle();

    step();
    chk("exp_m_q_empty", 32'(exp_m_q.size()), 32'd0);
    chk("exp_l_q_empty", 32'(exp_l_q.size()), 32'd0);
    chk("word_q_empty", 32'(word_q.size()), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
